// File: rtl/mmio_console.sv
// rtl/mmio_console.sv - Avalon-MM console agent: TX byte FIFO, 8N1 serialiser and sticky exit latch.
// Define CONSOLE_SIM_PRINT_EN to echo popped bytes and exit codes to the simulator console.
module mmio_console #(
   parameter int FIFO_DEPTH = 16,
   parameter int BIT_CYCLES = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [3:0]  address,
   input  logic        read,
   input  logic        write,
   input  logic [31:0] host_to_agent,
   output logic [31:0] agent_to_host,
   output logic        readdatavalid,
   output logic        waitrequest,
   output logic        tx,
   output logic        exit_valid,
   output logic [31:0] exit_code
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = $clog2(BIT_CYCLES);
   localparam logic [CW-1:0] LAST_CYC = CW'(BIT_CYCLES - 1);
   localparam logic [AW:0]   FULL_CNT = (AW + 1)'(FIFO_DEPTH);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   state_t        state, next_state;
   logic [7:0]    mem [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [AW:0]   count;
   logic          full, empty, push, pop, busy, bit_done;
   logic [CW-1:0] cyc_cnt;
   logic [2:0]    bit_idx;
   logic [7:0]    shift;
   logic [31:0]   status_word;

   // full comes from the count register, so a pop in the same cycle cannot release a stalled write
   assign full        = (count == FULL_CNT);
   assign empty       = (count == '0);
   assign waitrequest = write && (address == 4'h0) && full;
   assign push        = write && (address == 4'h0) && !full;
   assign busy        = (state != IDLE);
   assign bit_done    = (cyc_cnt == LAST_CYC);
   assign status_word = {16'h0, 8'(count), 5'h0, busy, empty, full};

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= host_to_agent[7:0];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= next_state;
   end

   always_comb begin
      next_state = state;
      pop        = 1'b0;
      tx         = 1'b1;
      case (state)
         IDLE: begin
            if (!empty) begin
               pop        = 1'b1;
               next_state = START;
            end
         end
         START: begin
            tx = 1'b0;
            if (bit_done) next_state = DATA;
         end
         DATA: begin
            tx = shift[0];
            if (bit_done && bit_idx == 3'd7) next_state = STOP;
         end
         STOP: begin
            if (bit_done) next_state = IDLE;
         end
         default: next_state = IDLE;
      endcase
   end

   // Bit timer idles at zero so every frame starts on a full-length start bit
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cyc_cnt <= '0;
         bit_idx <= '0;
         shift   <= '0;
      end else begin
         if (state == IDLE || bit_done) cyc_cnt <= '0;
         else                           cyc_cnt <= cyc_cnt + 1'b1;
         if (pop)                            shift <= mem[rd_ptr];
         else if (state == DATA && bit_done) shift <= {1'b0, shift[7:1]};
         if (state == START)                 bit_idx <= '0;
         else if (state == DATA && bit_done) bit_idx <= bit_idx + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         readdatavalid <= 1'b0;
         agent_to_host <= '0;
      end else begin
         readdatavalid <= read;
         if (read && address == 4'h4) agent_to_host <= status_word;
         else                         agent_to_host <= '0;
      end
   end

   // Only the first EXIT write is honoured; later ones are dropped until reset
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         exit_valid <= 1'b0;
         exit_code  <= '0;
      end else if (write && address == 4'h8 && !exit_valid) begin
         exit_valid <= 1'b1;
         exit_code  <= host_to_agent;
      end
   end

`ifdef CONSOLE_SIM_PRINT_EN
   always @(posedge clk) begin
      if (!rst && pop) $write("%c", mem[rd_ptr]);
      if (!rst && write && address == 4'h8 && !exit_valid) $display("exit(%h)", host_to_agent);
   end
`else
`endif

endmodule
